// File: rtl/axil2wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone bridge.
// Response encodings, the bridge FSM state type, a generic request record
// and the helper that maps a Wishbone termination onto an AXI response.
package axil2wb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB_WR  = 3'd1,
        WB_RD  = 3'd2,
        B_RESP = 3'd3,
        R_RESP = 3'd4
    } axil2wb_state_e;

    typedef struct packed {
        logic [REQ_ADDR_W-1:0]   addr;
        logic [REQ_DATA_W-1:0]   data;
        logic [REQ_DATA_W/8-1:0] strb;
        logic                    we;
    } axil2wb_req_t;

    // err outranks ack; with neither present the cycle ended on the watchdog.
    function automatic logic [1:0] term_resp(input logic ack, input logic err);
        logic [1:0] resp;
        if (err) begin
            resp = RESP_SLVERR;
        end else if (ack) begin
            resp = RESP_OKAY;
        end else begin
            resp = RESP_DECERR;
        end
        return resp;
    endfunction

endpackage

// File: rtl/axil2wb_req_buf.sv
// One-entry holding buffer for a single AXI request channel.
// ready is registered and mirrors the inverse of the full flag; a handshake
// fills the entry and a consume pulse (Wishbone cycle launch) empties it.
module axil2wb_req_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             consume_i,
    output logic             ready_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    logic             full_q;
    logic             full_d;
    logic             ready_q;
    logic [WIDTH-1:0] data_q;
    logic             hs_s;

    assign hs_s = valid_i & ready_q;

    // Next fill state: a launch empties the entry, a handshake fills it.
    always_comb begin
        full_d = full_q;
        if (consume_i) begin
            full_d = 1'b0;
        end else if (hs_s) begin
            full_d = 1'b1;
        end else begin
            full_d = full_q;
        end
    end

    // Fill flag, registered ready and captured payload.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            full_q  <= 1'b0;
            ready_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            full_q  <= full_d;
            ready_q <= ~full_d;
            if (hs_s) begin
                data_q <= data_i;
            end
        end
    end

    assign ready_o = ready_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axil2wb_arb_bridge.sv
// AXI4-Lite slave to Wishbone B4 classic master bridge.
// Independent AW/W/AR holding buffers, round-robin read/write selection on
// ties, one outstanding Wishbone cycle and per-channel response routing.
// Optional bus watchdog enabled by defining AXIL2WB_TIMEOUT_EN.
module axil2wb_arb_bridge
    import axil2wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr_i,
    input  logic                    s_axil_awvalid_i,
    output logic                    s_axil_awready_o,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb_i,
    input  logic                    s_axil_wvalid_i,
    output logic                    s_axil_wready_o,
    output logic [1:0]              s_axil_bresp_o,
    output logic                    s_axil_bvalid_o,
    input  logic                    s_axil_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr_i,
    input  logic                    s_axil_arvalid_i,
    output logic                    s_axil_arready_o,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata_o,
    output logic [1:0]              s_axil_rresp_o,
    output logic                    s_axil_rvalid_o,
    input  logic                    s_axil_rready_i,
    output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
    output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   m_wb_dat_i,
    output logic [DATA_WIDTH/8-1:0] m_wb_sel_o,
    output logic                    m_wb_we_o,
    output logic                    m_wb_stb_o,
    output logic                    m_wb_cyc_o,
    input  logic                    m_wb_ack_i,
    input  logic                    m_wb_err_i
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WBUF_W = DATA_WIDTH + STRB_W;

    axil2wb_state_e          state_q;
    logic                    last_wr_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic [DATA_WIDTH-1:0]   dat_q;
    logic [STRB_W-1:0]       sel_q;
    logic                    we_q;
    logic                    cyc_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [1:0]              rresp_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    aw_full_s;
    logic                    w_full_s;
    logic                    ar_full_s;
    logic [ADDR_WIDTH-1:0]   aw_addr_s;
    logic [ADDR_WIDTH-1:0]   ar_addr_s;
    logic [WBUF_W-1:0]       w_buf_s;
    logic                    wr_elig_s;
    logic                    grant_wr_s;
    logic                    grant_rd_s;
    logic                    timeout_s;
    logic                    done_s;
    logic [1:0]              resp_s;

    axil2wb_req_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .valid_i   (s_axil_awvalid_i),
        .data_i    (s_axil_awaddr_i),
        .consume_i (grant_wr_s),
        .ready_o   (s_axil_awready_o),
        .full_o    (aw_full_s),
        .data_o    (aw_addr_s)
    );

    axil2wb_req_buf #(.WIDTH(WBUF_W)) u_w_buf (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .valid_i   (s_axil_wvalid_i),
        .data_i    ({s_axil_wdata_i, s_axil_wstrb_i}),
        .consume_i (grant_wr_s),
        .ready_o   (s_axil_wready_o),
        .full_o    (w_full_s),
        .data_o    (w_buf_s)
    );

    axil2wb_req_buf #(.WIDTH(ADDR_WIDTH)) u_ar_buf (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .valid_i   (s_axil_arvalid_i),
        .data_i    (s_axil_araddr_i),
        .consume_i (grant_rd_s),
        .ready_o   (s_axil_arready_o),
        .full_o    (ar_full_s),
        .data_o    (ar_addr_s)
    );

    assign wr_elig_s = aw_full_s & w_full_s;

    // Arbitration in IDLE: a lone request wins, a tie goes opposite to last_wr.
    always_comb begin
        grant_wr_s = 1'b0;
        grant_rd_s = 1'b0;
        if (state_q == IDLE) begin
            if (wr_elig_s && ar_full_s) begin
                grant_wr_s = ~last_wr_q;
                grant_rd_s = last_wr_q;
            end else begin
                grant_wr_s = wr_elig_s;
                grant_rd_s = ar_full_s;
            end
        end else begin
            grant_wr_s = 1'b0;
            grant_rd_s = 1'b0;
        end
    end

`ifdef AXIL2WB_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wdog_q;

    // Watchdog: restarts on each launch and counts every cycle cyc is high.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wdog_q <= {CNT_W{1'b0}};
        end else if (grant_wr_s || grant_rd_s) begin
            wdog_q <= {CNT_W{1'b0}};
        end else if (cyc_q) begin
            wdog_q <= wdog_q + CNT_W'(1);
        end
    end

    assign timeout_s = cyc_q & (wdog_q == CNT_LAST);
`else
    assign timeout_s = 1'b0;
`endif

    assign done_s = m_wb_ack_i | m_wb_err_i | timeout_s;
    assign resp_s = term_resp(m_wb_ack_i, m_wb_err_i);

    // Bridge FSM: launch a Wishbone cycle, terminate it, then hold the response.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            adr_q     <= {ADDR_WIDTH{1'b0}};
            dat_q     <= {DATA_WIDTH{1'b0}};
            sel_q     <= {STRB_W{1'b0}};
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_wr_s) begin
                        state_q   <= WB_WR;
                        last_wr_q <= 1'b1;
                        adr_q     <= aw_addr_s;
                        dat_q     <= w_buf_s[WBUF_W-1:STRB_W];
                        sel_q     <= w_buf_s[STRB_W-1:0];
                        we_q      <= 1'b1;
                        cyc_q     <= 1'b1;
                    end else if (grant_rd_s) begin
                        state_q   <= WB_RD;
                        last_wr_q <= 1'b0;
                        adr_q     <= ar_addr_s;
                        sel_q     <= {STRB_W{1'b1}};
                        we_q      <= 1'b0;
                        cyc_q     <= 1'b1;
                    end
                end
                WB_WR: begin
                    if (done_s) begin
                        cyc_q    <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= resp_s;
                        state_q  <= B_RESP;
                    end
                end
                WB_RD: begin
                    if (done_s) begin
                        cyc_q    <= 1'b0;
                        rvalid_q <= 1'b1;
                        rresp_q  <= resp_s;
                        rdata_q  <= (resp_s == RESP_OKAY) ? m_wb_dat_i : {DATA_WIDTH{1'b0}};
                        state_q  <= R_RESP;
                    end
                end
                B_RESP: begin
                    if (s_axil_bready_i) begin
                        bvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                R_RESP: begin
                    if (s_axil_rready_i) begin
                        rvalid_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                end
            endcase
        end
    end

    assign m_wb_adr_o      = adr_q;
    assign m_wb_dat_o      = dat_q;
    assign m_wb_sel_o      = sel_q;
    assign m_wb_we_o       = we_q;
    assign m_wb_stb_o      = cyc_q;
    assign m_wb_cyc_o      = cyc_q;
    assign s_axil_bvalid_o = bvalid_q;
    assign s_axil_bresp_o  = bresp_q;
    assign s_axil_rvalid_o = rvalid_q;
    assign s_axil_rresp_o  = rresp_q;
    assign s_axil_rdata_o  = rdata_q;

endmodule
